ps2_scancode_decoder_axis: RTL



---
 rtl/ps2_pkg.sv | 91 +++++++++
 rtl/axis_sync_fifo.sv | 55 +++++
 rtl/ps2_scancode_decoder_axis.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and the set-2 to ASCII translation
// used by the PS/2 scancode decoder.
package ps2_pkg;

  // Prefix bytes of multi-byte sequences
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  // Modifier keys
  localparam logic [7:0] PS2_SHIFT_L = 8'h12;
  localparam logic [7:0] PS2_SHIFT_R = 8'h59;
  localparam logic [7:0] PS2_CTRL    = 8'h14;
  localparam logic [7:0] PS2_CAPS    = 8'h58;

  // Extended keys that still carry an ASCII value
  localparam logic [7:0] PS2_ENTER    = 8'h5A;
  localparam logic [7:0] PS2_KP_SLASH = 8'h4A;

  // Keyboard status / error bytes that never represent a key
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  // Bytes following E1 in the Pause sequence
  localparam logic [2:0] PS2_PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } ps2_state_t;

  // Non-extended set-2 code to US ASCII; 0x00 when the key has no character.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code,
                                              input logic shift,
                                              input logic caps,
                                              input logic ctrl);
    logic [7:0] lc;
    logic [7:0] r;
    lc = 8'h00;
    r  = 8'h00;
    case (code)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      8'h16: r = shift ? "!" : "1";
      8'h1E: r = shift ? "@" : "2";
      8'h26: r = shift ? "#" : "3";
      8'h25: r = shift ? "$" : "4";
      8'h2E: r = shift ? "%" : "5";
      8'h36: r = shift ? "^" : "6";
      8'h3D: r = shift ? "&" : "7";
      8'h3E: r = shift ? "*" : "8";
      8'h46: r = shift ? "(" : "9";
      8'h45: r = shift ? ")" : "0";
      8'h0E: r = shift ? "~" : 8'h60;
      8'h4E: r = shift ? "_" : "-";
      8'h55: r = shift ? "+" : "=";
      8'h54: r = shift ? "{" : "[";
      8'h5B: r = shift ? "}" : "]";
      8'h5D: r = shift ? "|" : 8'h5C;
      8'h4C: r = shift ? ":" : ";";
      8'h52: r = shift ? 8'h22 : 8'h27;
      8'h41: r = shift ? "<" : ",";
      8'h49: r = shift ? ">" : ".";
      8'h4A: r = shift ? "?" : "/";
      8'h29: r = 8'h20;
      8'h5A: r = 8'h0D;
      8'h66: r = 8'h08;
      8'h76: r = 8'h1B;
      8'h0D: r = 8'h09;
      default: ;
    endcase
    if (lc != 8'h00) begin
      if (ctrl)              r = lc & 8'h1F;
      else if (shift ^ caps) r = lc & 8'hDF;
      else                   r = lc;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word fall-through synchronous FIFO with a power-of-2 depth.
module axis_sync_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              valid,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign valid    = (count != '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && valid;
  // Head word is forced to zero while empty so the output is clean after reset
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // Storage is not reset; only the pointers and count qualify it
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder_axis.sv
// Set-2 scancode stream to key-event stream: strips E0/F0/E1 prefixes,
// tracks Shift/Ctrl/Caps Lock and queues one event word per make/break.
module ps2_scancode_decoder_axis
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int EMIT_BREAK = 1
) (
  input  logic        axis_aclk_i,
  input  logic        axis_areset_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  input  logic [7:0]  s_axis_tdata_i,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [15:0] m_axis_tdata_o,
  output logic [3:0]  m_axis_tuser_o
);

  localparam int WORD_W = 20;

  ps2_state_t        state, nxt_state;
  logic [2:0]        skip_cnt, nxt_skip;
  logic              shift_l, nxt_shift_l;
  logic              shift_r, nxt_shift_r;
  logic              ctrl, nxt_ctrl;
  logic              caps_lock, nxt_caps;
  logic              caps_held, nxt_caps_held;
  logic              key_evt, is_ext, is_brk, pause_evt, discard;
  logic [7:0]        code, ascii;
  logic              fifo_full, accept, push;
  logic [WORD_W-1:0] word, head;

  assign code   = s_axis_tdata_i;
  // Ready is held low while reset is applied even though the FIFO is empty
  assign s_axis_tready_o = !fifo_full && !axis_areset_i;
  assign accept  = s_axis_tvalid_i && s_axis_tready_o;
  assign discard = (code == PS2_BAT) || (code == PS2_ACK) || (code == PS2_RESEND) ||
                   (code == PS2_ERR_LO) || (code == PS2_ERR_HI);

  // Next state, modifier update and event word for the byte on the input
  always_comb begin
    nxt_state     = state;
    nxt_skip      = skip_cnt;
    nxt_shift_l   = shift_l;
    nxt_shift_r   = shift_r;
    nxt_ctrl      = ctrl;
    nxt_caps      = caps_lock;
    nxt_caps_held = caps_held;
    key_evt       = 1'b0;
    is_ext        = 1'b0;
    is_brk        = 1'b0;
    pause_evt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (code == PS2_F0)      nxt_state = ST_F0;
        else if (code == PS2_E0) nxt_state = ST_E0;
        else if (code == PS2_E1) begin
          nxt_state = ST_SKIP;
          nxt_skip  = PS2_PAUSE_LEN;
        end else if (!discard)   key_evt = 1'b1;
      end
      ST_E0: begin
        if (code == PS2_F0)      nxt_state = ST_E0F0;
        else if (code != PS2_E0) begin
          key_evt   = 1'b1;
          is_ext    = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      ST_F0: begin
        key_evt   = 1'b1;
        is_brk    = 1'b1;
        nxt_state = ST_IDLE;
      end
      ST_E0F0: begin
        key_evt   = 1'b1;
        is_ext    = 1'b1;
        is_brk    = 1'b1;
        nxt_state = ST_IDLE;
      end
      ST_SKIP: begin
        nxt_skip = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) begin
          pause_evt = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Extended 12/59 are Print Screen fake shifts and leave Shift alone
    if (key_evt) begin
      if (!is_ext && code == PS2_SHIFT_L) nxt_shift_l = !is_brk;
      if (!is_ext && code == PS2_SHIFT_R) nxt_shift_r = !is_brk;
      if (code == PS2_CTRL)               nxt_ctrl    = !is_brk;
      if (!is_ext && code == PS2_CAPS) begin
        if (is_brk) nxt_caps_held = 1'b0;
        else begin
          if (!caps_held) nxt_caps = !caps_lock;
          nxt_caps_held = 1'b1;
        end
      end
    end

    // ASCII uses the modifier state from before this byte
    if (is_ext) begin
      if (code == PS2_ENTER)         ascii = 8'h0D;
      else if (code == PS2_KP_SLASH) ascii = 8'h2F;
      else                           ascii = 8'h00;
    end else begin
      ascii = ps2_to_ascii(code, shift_l | shift_r, caps_lock, ctrl);
    end

    if (pause_evt) word = {PS2_E1, 8'h00, 4'b0000};
    else           word = {code, ascii, nxt_caps, nxt_shift_l | nxt_shift_r, is_ext, is_brk};

    push = accept && (pause_evt || (key_evt && (!is_brk || (EMIT_BREAK != 0))));
  end

  // Decoder FSM and modifier registers advance once per accepted byte
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      ctrl      <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
    end else if (accept) begin
      state     <= nxt_state;
      skip_cnt  <= nxt_skip;
      shift_l   <= nxt_shift_l;
      shift_r   <= nxt_shift_r;
      ctrl      <= nxt_ctrl;
      caps_lock <= nxt_caps;
      caps_held <= nxt_caps_held;
    end
  end

  axis_sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (axis_aclk_i),
    .rst       (axis_areset_i),
    .push      (push),
    .push_data (word),
    .full      (fifo_full),
    .valid     (m_axis_tvalid_o),
    .pop       (m_axis_tready_i),
    .pop_data  (head)
  );

  assign m_axis_tdata_o = head[19:4];
  assign m_axis_tuser_o = head[3:0];

endmodule
